// File: rtl/vslc_pkg.sv
// Shared constants and helpers for the VSLC input conditioner, core and board top.
package vslc_pkg;

    localparam int VSLC_N_CH         = 4;
    localparam int VSLC_PRESCALE_DEF = 12000;
    localparam int VSLC_DEBOUNCE_DEF = 5;
    localparam logic [VSLC_N_CH-1:0] VSLC_INVERT_DEF = 4'b0001;

    // What a debounce channel does with its counter in a given cycle.
    typedef enum logic [1:0] {
        DB_HOLD   = 2'd0,  // no tick: everything holds
        DB_IDLE   = 2'd1,  // tick, level matches: abort any pending change
        DB_COUNT  = 2'd2,  // tick, level differs: keep counting
        DB_COMMIT = 2'd3   // tick, level differed long enough: accept it
    } vslc_db_action_e;

    // Counter width able to hold 0..n-1 with one bit of headroom.
    function automatic int vslc_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/vslc_input_conditioner_if.sv
// Bundle of pad inputs, scan strobe and conditioned outputs of the input stage.
//
// Handshake: scan_strobe is a single-cycle request with no back-pressure; the
// image, image_rise and image_fall fields are updated on the clock edge that
// samples scan_strobe high and hold until the next such edge. image_valid rises
// with the first image after reset and stays high. rise_pulse and fall_pulse
// are single-cycle qualifiers of the debounced level change seen in that cycle.
interface vslc_input_conditioner_if
    import vslc_pkg::*;
#(
    parameter int N_CH = VSLC_N_CH
);
    logic [N_CH-1:0] btn_raw;
    logic            scan_strobe;
    logic            tick;
    logic [N_CH-1:0] debounced;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] image;
    logic [N_CH-1:0] image_rise;
    logic [N_CH-1:0] image_fall;
    logic            image_valid;

    modport master (
        output btn_raw, scan_strobe,
        input  tick, debounced, rise_pulse, fall_pulse,
        input  image, image_rise, image_fall, image_valid
    );

    modport slave (
        input  btn_raw, scan_strobe,
        output tick, debounced, rise_pulse, fall_pulse,
        output image, image_rise, image_fall, image_valid
    );
endinterface

// File: rtl/vslc_debounce_ch.sv
// One input channel: 2-FF synchroniser, polarity fix, tick-based debounce and
// registered rise/fall pulses. The *_evt_o outputs flag the change that the
// coming clock edge will commit, so the top can fold it into the scan image
// in the same cycle it happens.
module vslc_debounce_ch
    import vslc_pkg::*;
#(
    parameter int   DEBOUNCE_TICKS = VSLC_DEBOUNCE_DEF,
    parameter logic INVERT         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic tick_i,
    output logic debounced_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    localparam int CW = vslc_cnt_w(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic            s1_q, s2_q;
    logic            pol;
    logic            deb_q, deb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    vslc_db_action_e action;

    assign pol = s2_q ^ INVERT;

    // Decide the debounce action for this cycle and derive next state from it.
    always_comb begin
        action = DB_HOLD;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (tick_i) begin
            if (pol == deb_q) begin
                action = DB_IDLE;
            end else if (cnt_q == CNT_LAST) begin
                action = DB_COMMIT;
            end else begin
                action = DB_COUNT;
            end
        end
        case (action)
            DB_IDLE:   cnt_d = '0;
            DB_COUNT:  cnt_d = cnt_q + CW'(1);
            DB_COMMIT: begin
                deb_d  = pol;
                cnt_d  = '0;
                rise_d = pol;
                fall_d = ~pol;
            end
            default:   ;
        endcase
    end

    // Synchroniser, debounce state and pulse registers; idle pads reset to the
    // inactive level so nothing debounces spuriously out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= INVERT;
            s2_q   <= INVERT;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= btn_raw_i;
            s2_q   <= s1_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign debounced_o = deb_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign rise_evt_o  = rise_d;
    assign fall_evt_o  = fall_d;

endmodule

// File: rtl/vslc_input_conditioner.sv
// Input stage for the VSLC core: shared debounce prescaler, per-channel
// conditioning, and a PLC-style input image latched on each scan strobe with
// sticky edge capture between strobes.
module vslc_input_conditioner
    import vslc_pkg::*;
#(
    parameter int              N_CH           = VSLC_N_CH,
    parameter int              PRESCALE       = VSLC_PRESCALE_DEF,
    parameter int              DEBOUNCE_TICKS = VSLC_DEBOUNCE_DEF,
    parameter logic [N_CH-1:0] INVERT_MASK    = VSLC_INVERT_DEF
) (
    input logic                     clk,
    input logic                     rst,
    vslc_input_conditioner_if.slave bus
);

    localparam int PW = vslc_cnt_w(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]   pre_q, pre_d;
    logic            tick;

    logic [N_CH-1:0] deb_w, rise_w, fall_w, rise_evt, fall_evt;

    logic [N_CH-1:0] pend_r_q, pend_r_d;
    logic [N_CH-1:0] pend_f_q, pend_f_d;
    logic [N_CH-1:0] image_q, image_d;
    logic [N_CH-1:0] image_rise_q, image_rise_d;
    logic [N_CH-1:0] image_fall_q, image_fall_d;
    logic            valid_q, valid_d;

    assign tick = (pre_q == PRE_LAST);

    // Prescaler next state: free-running 0..PRESCALE-1.
    always_comb begin
        pre_d = pre_q + PW'(1);
        if (tick) begin
            pre_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        vslc_debounce_ch #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .INVERT         (INVERT_MASK[g])
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .btn_raw_i   (bus.btn_raw[g]),
            .tick_i      (tick),
            .debounced_o (deb_w[g]),
            .rise_o      (rise_w[g]),
            .fall_o      (fall_w[g]),
            .rise_evt_o  (rise_evt[g]),
            .fall_evt_o  (fall_evt[g])
        );
    end

    // Sticky edge accumulation and image capture. An edge committed on the
    // strobe edge goes straight into the new image and is not carried over.
    always_comb begin
        pend_r_d     = pend_r_q | rise_evt;
        pend_f_d     = pend_f_q | fall_evt;
        image_d      = image_q;
        image_rise_d = image_rise_q;
        image_fall_d = image_fall_q;
        valid_d      = valid_q;
        if (bus.scan_strobe) begin
            image_d      = deb_w;
            image_rise_d = pend_r_q | rise_evt;
            image_fall_d = pend_f_q | fall_evt;
            pend_r_d     = '0;
            pend_f_d     = '0;
            valid_d      = 1'b1;
        end
    end

    // Image and sticky registers; reset discards everything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r_q     <= '0;
            pend_f_q     <= '0;
            image_q      <= '0;
            image_rise_q <= '0;
            image_fall_q <= '0;
            valid_q      <= 1'b0;
        end else begin
            pend_r_q     <= pend_r_d;
            pend_f_q     <= pend_f_d;
            image_q      <= image_d;
            image_rise_q <= image_rise_d;
            image_fall_q <= image_fall_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.tick        = tick;
    assign bus.debounced   = deb_w;
    assign bus.rise_pulse  = rise_w;
    assign bus.fall_pulse  = fall_w;
    assign bus.image       = image_q;
    assign bus.image_rise  = image_rise_q;
    assign bus.image_fall  = image_fall_q;
    assign bus.image_valid = valid_q;

endmodule

// File: tb/tb_vslc_input_conditioner.sv
// Bench for the VSLC input conditioner: directed scenarios plus random pad
// activity, compared against a window-based reference model.
module tb_vslc_input_conditioner;
    import vslc_pkg::*;

    localparam int N = 4;
    localparam int P = 4;
    localparam int D = 3;
    localparam int W = 26;
    localparam logic [N-1:0] INV = 4'b0001;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vslc_input_conditioner_if #(.N_CH(N)) bus ();

    vslc_input_conditioner #(
        .N_CH           (N),
        .PRESCALE       (P),
        .DEBOUNCE_TICKS (D),
        .INVERT_MASK    (INV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard
    logic [W-1:0]    st_q[$];
    logic [12:0]     img_q[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              cyc = 0;
    bit              done = 0;
    int              rise_cnt[N];
    int              fall_cnt[N];
    int              last_rise[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: level history sampled on each tick; a change is
    // accepted when the last D tick samples all disagree with the level.
    logic [N-1:0] inv_v = INV;
    logic [N-1:0] m_s1, m_s2, m_deb, m_pr, m_pf, m_img, m_ir, m_if;
    logic         m_valid;
    int           m_k;
    bit           m_hist[N][$];

    function automatic bit m_flip(input int ch);
        logic pol;
        int   idx;
        if ((m_k % P) != P - 1) return 1'b0;
        pol = m_s2[ch] ^ inv_v[ch];
        if (pol == m_deb[ch]) return 1'b0;
        for (int j = 1; j < D; j++) begin
            idx = m_hist[ch].size() - j;
            if (idx < 0) return 1'b0;
            if (m_hist[ch][idx] == m_deb[ch]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] raw, input logic stb);
        logic [N-1:0] er, ef;
        er = '0;
        ef = '0;
        if (r) begin
            m_s1 = inv_v; m_s2 = inv_v; m_k = 0; m_deb = '0;
            m_pr = '0; m_pf = '0; m_img = '0; m_ir = '0; m_if = '0; m_valid = 1'b0;
            for (int ch = 0; ch < N; ch++) m_hist[ch].delete();
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                if (m_flip(ch)) begin
                    if (m_deb[ch]) ef[ch] = 1'b1;
                    else           er[ch] = 1'b1;
                end
            end
            if ((m_k % P) == P - 1) begin
                for (int ch = 0; ch < N; ch++) begin
                    m_hist[ch].push_back(m_s2[ch] ^ inv_v[ch]);
                    if (m_hist[ch].size() > D) void'(m_hist[ch].pop_front());
                end
            end
            if (stb) begin
                m_valid = 1'b1;
                m_img = m_deb;
                m_ir = m_pr | er;
                m_if = m_pf | ef;
                m_pr = '0;
                m_pf = '0;
                img_q.push_back({1'b1, m_img, m_ir, m_if});
            end else begin
                m_pr = m_pr | er;
                m_pf = m_pf | ef;
            end
            m_deb = m_deb ^ (er | ef);
            m_s2 = m_s1;
            m_s1 = raw;
            m_k++;
        end
        st_q.push_back({((m_k % P) == P - 1), m_deb, er, ef, m_valid, m_img, m_ir, m_if});
    endtask

    // Driver: inputs change on the falling edge, model predicts the next rising edge.
    task automatic step(input logic r, input logic [N-1:0] raw, input logic stb);
        @(negedge clk);
        rst = r;
        bus.btn_raw = raw;
        bus.scan_strobe = stb;
        model_edge(r, raw, stb);
    endtask

    // Monitor: every cycle compares outputs; on a strobe also checks the image.
    always @(posedge clk) begin : monitor
        logic        s_stb, s_rst;
        logic [W-1:0] e;
        logic [12:0] ei;
        if (!done) begin
            s_stb = bus.scan_strobe;
            s_rst = rst;
            cyc++;
            #1;
            if (st_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL state_queue: no expected entry at cycle %0d", cyc);
            end else begin
                e = st_q.pop_front();
                check("state", {bus.tick, bus.debounced, bus.rise_pulse, bus.fall_pulse,
                                bus.image_valid, bus.image, bus.image_rise, bus.image_fall}, e);
            end
            if (s_stb && !s_rst) begin
                if (img_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL image_queue: no expected image at cycle %0d", cyc);
                end else begin
                    ei = img_q.pop_front();
                    check("image", {bus.image_valid, bus.image, bus.image_rise, bus.image_fall}, ei);
                end
            end
            for (int ch = 0; ch < N; ch++) begin
                if (bus.rise_pulse[ch]) begin rise_cnt[ch]++; last_rise[ch] = cyc; end
                if (bus.fall_pulse[ch]) fall_cnt[ch]++;
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        logic [N-1:0] raw;
        int chg, lat, left, r2, f2;
        bit found;
        for (int ch = 0; ch < N; ch++) begin rise_cnt[ch] = 0; fall_cnt[ch] = 0; last_rise[ch] = 0; end
        raw = 4'b0001;
        rst = 1'b1;
        bus.btn_raw = raw;
        bus.scan_strobe = 1'b0;
        model_edge(1'b1, raw, 1'b0);
        repeat (3) step(1'b1, raw, 1'b0);

        // Idle pads out of reset: nothing debounces
        repeat (20) step(1'b0, raw, 1'b0);
        check("idle_debounced", bus.debounced, 0);
        check("idle_valid", bus.image_valid, 0);
        step(1'b0, raw, 1'b1);

        // Clean press on ch1
        raw[1] = 1'b1;
        step(1'b0, raw, 1'b0);
        chg = cyc + 1;
        repeat (19) step(1'b0, raw, 1'b0);
        lat = last_rise[1] - chg;
        check("ch1_latency_in_10_14", (lat >= 10 && lat <= 14), 1);
        check("ch1_rise_count", rise_cnt[1], 1);
        check("ch1_fall_count", fall_cnt[1], 0);
        check("ch1_level", bus.debounced[1], 1);

        // Bouncing ch2 then settled high
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) raw[2] = ~raw[2];
            step(1'b0, raw, 1'b0);
        end
        check("ch2_no_change_while_bouncing", rise_cnt[2] + fall_cnt[2], 0);
        raw[2] = 1'b1;
        repeat (20) step(1'b0, raw, 1'b0);
        check("ch2_single_rise", rise_cnt[2], 1);

        // Active-low ch0 pressed
        raw[0] = 1'b0;
        repeat (20) step(1'b0, raw, 1'b0);
        check("ch0_level", bus.debounced[0], 1);
        check("ch0_rise_count", rise_cnt[0], 1);

        // Sticky press+release of ch3 between strobes
        step(1'b0, raw, 1'b1);
        raw[3] = 1'b1;
        repeat (20) step(1'b0, raw, 1'b0);
        raw[3] = 1'b0;
        repeat (20) step(1'b0, raw, 1'b0);
        step(1'b0, raw, 1'b1);
        step(1'b0, raw, 1'b0);
        check("ch3_image", bus.image[3], 0);
        check("ch3_image_rise", bus.image_rise[3], 1);
        check("ch3_image_fall", bus.image_fall[3], 1);
        step(1'b0, raw, 1'b1);
        step(1'b0, raw, 1'b1);
        step(1'b0, raw, 1'b0);
        check("ch3_image_rise_cleared", bus.image_rise[3], 0);
        check("ch3_image_fall_cleared", bus.image_fall[3], 0);

        // Strobe coincident with the ch1 rise
        raw[1] = 1'b0;
        repeat (20) step(1'b0, raw, 1'b0);
        step(1'b0, raw, 1'b1);
        raw[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            found = m_flip(1);
            step(1'b0, raw, found);
        end
        step(1'b0, raw, 1'b0);
        check("coinc_found", found, 1);
        check("coinc_image", bus.image[1], 0);
        check("coinc_image_rise", bus.image_rise[1], 1);
        repeat (5) step(1'b0, raw, 1'b0);
        step(1'b0, raw, 1'b1);
        step(1'b0, raw, 1'b0);
        check("after_coinc_image", bus.image[1], 1);
        check("after_coinc_image_rise", bus.image_rise[1], 0);

        // Reset in the middle of a pending release of ch2
        raw[2] = 1'b0;
        f2 = fall_cnt[2];
        repeat (6) step(1'b0, raw, 1'b0);
        step(1'b1, raw, 1'b0);
        repeat (20) step(1'b0, raw, 1'b0);
        check("ch2_no_fall_after_reset", fall_cnt[2], f2);

        // Reset discards a sticky edge
        raw[3] = 1'b1;
        repeat (20) step(1'b0, raw, 1'b0);
        r2 = rise_cnt[3];
        step(1'b1, raw, 1'b0);
        step(1'b0, raw, 1'b0);
        step(1'b0, raw, 1'b1);
        step(1'b0, raw, 1'b0);
        check("ch3_sticky_discarded", bus.image_rise[3], 0);
        check("valid_after_reset_strobe", bus.image_valid, 1);
        check("ch3_rise_seen_before_reset", r2, 2);

        // Random pad activity, strobes and occasional resets
        left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (left == 0) begin
                raw = 4'($urandom_range(0, 15));
                left = $urandom_range(1, 24);
            end
            left--;
            step(($urandom_range(0, 399) == 0), raw, ($urandom_range(0, 7) == 0));
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        check("state_queue_drained", st_q.size(), 0);
        check("image_queue_drained", img_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
